// File: rtl/ddr3_top_ex_lfsr_chk_if.sv
// Bus bundle for the LFSR pattern generator/checker.
// The master drives the generator controls and the read-back words.
// The slave (the LFSR block) returns the pattern and the checker status.
interface ddr3_top_ex_lfsr_chk_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] ldata;
    logic [WIDTH-1:0] data;
    logic             check_valid;
    logic [WIDTH-1:0] check_data;
    logic             clear_err;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] first_err_got;
    logic [WIDTH-1:0] first_err_exp;

    modport master (
        output enable, pause, load, ldata, check_valid, check_data, clear_err,
        input  data, err, err_sticky, err_count, first_err_got, first_err_exp
    );

    modport slave (
        input  enable, pause, load, ldata, check_valid, check_data, clear_err,
        output data, err, err_sticky, err_count, first_err_got, first_err_exp
    );
endinterface

// File: rtl/ddr3_top_ex_lfsr_chk.sv
// Galois LFSR pattern generator with a built-in read-back checker.
// The same block serves as the write-data source (checker unused) and as
// the read-side reference that regenerates the sequence and counts
// mismatches, capturing the first failing word pair.
module ddr3_top_ex_lfsr_chk #(
    parameter int          WIDTH = 8,
    parameter logic [63:0] POLY  = 64'h1D,
    parameter logic [63:0] SEED  = 64'd32,
    parameter int          STEPS = 1,
    parameter int          CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ddr3_top_ex_lfsr_chk_if.slave   bus
);
    localparam logic [WIDTH-1:0] POLY_W  = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One Galois iteration: shift up, MSB wraps into bit 0 and is XORed
    // into every tap selected by the polynomial mask.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        n[0] = s[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = s[i-1] ^ (POLY_W[i] & s[WIDTH-1]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] adv_data;
    logic             err_reg, err_next;
    logic             sticky_reg, sticky_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] got_reg, got_next;
    logic [WIDTH-1:0] exp_reg, exp_next;
    logic             mismatch;

    // Next pattern: restart, load (zero load maps to seed to avoid the
    // all-zero lock-up state), STEPS-fold advance, or hold.
    always_comb begin
        adv_data = data_reg;
        for (int k = 0; k < STEPS; k++) begin
            adv_data = lfsr_step(adv_data);
        end
        data_next = data_reg;
        if (!bus.enable) begin
            data_next = SEED_W;
        end else if (bus.load) begin
            data_next = (bus.ldata == '0) ? SEED_W : bus.ldata;
        end else if (!bus.pause) begin
            data_next = adv_data;
        end
    end

    // Checker status: a clear takes effect before a same-cycle mismatch is
    // recorded, so that mismatch becomes the new first failure.
    always_comb begin
        mismatch    = bus.enable && bus.check_valid && (bus.check_data != data_reg);
        err_next    = mismatch;
        sticky_next = sticky_reg;
        cnt_next    = cnt_reg;
        got_next    = got_reg;
        exp_next    = exp_reg;
        if (bus.clear_err) begin
            sticky_next = 1'b0;
            cnt_next    = '0;
            got_next    = '0;
            exp_next    = '0;
        end
        if (mismatch) begin
            if (!sticky_next) begin
                got_next = bus.check_data;
                exp_next = data_reg;
            end
            sticky_next = 1'b1;
            if (cnt_next != CNT_MAX) begin
                cnt_next = cnt_next + 1'b1;
            end
        end
    end

    // State registers with asynchronous return to the reset values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= SEED_W;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
            got_reg    <= '0;
            exp_reg    <= '0;
        end else begin
            data_reg   <= data_next;
            err_reg    <= err_next;
            sticky_reg <= sticky_next;
            cnt_reg    <= cnt_next;
            got_reg    <= got_next;
            exp_reg    <= exp_next;
        end
    end

    assign bus.data          = data_reg;
    assign bus.err           = err_reg;
    assign bus.err_sticky    = sticky_reg;
    assign bus.err_count     = cnt_reg;
    assign bus.first_err_got = got_reg;
    assign bus.first_err_exp = exp_reg;
endmodule

// File: tb/tb_ddr3_top_ex_lfsr_chk.sv
// Bench for the LFSR generator/checker: default instance against a
// polynomial-arithmetic reference model, plus STEPS=2 and CNT_W=2 variants.
module tb_ddr3_top_ex_lfsr_chk;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddr3_top_ex_lfsr_chk_if #(.WIDTH(8), .CNT_W(16)) d_if ();
    ddr3_top_ex_lfsr_chk_if #(.WIDTH(8), .CNT_W(16)) s2_if ();
    ddr3_top_ex_lfsr_chk_if #(.WIDTH(8), .CNT_W(2))  c2_if ();

    ddr3_top_ex_lfsr_chk u_def (.clk(clk), .reset_n(reset_n), .bus(d_if));
    ddr3_top_ex_lfsr_chk #(.STEPS(2)) u_s2 (.clk(clk), .reset_n(reset_n), .bus(s2_if));
    ddr3_top_ex_lfsr_chk #(.CNT_W(2)) u_c2 (.clk(clk), .reset_n(reset_n), .bus(c2_if));

    int errors = 0;
    int checks = 0;

    // Reference model of the default instance.
    logic [7:0] m_data = 8'h20;
    logic       m_err = 1'b0, m_sticky = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_fg = 8'h00, m_fe = 8'h00;

    // Multiply by x modulo p(x) = x^8+x^4+x^3+x^2+1 (0x11D).
    function automatic logic [7:0] mulx(input logic [7:0] s);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_def(input string tag);
        check({tag, ".data"},  d_if.data, m_data);
        check({tag, ".err"},   d_if.err, m_err);
        check({tag, ".stky"},  d_if.err_sticky, m_sticky);
        check({tag, ".cnt"},   d_if.err_count, m_cnt);
        check({tag, ".fgot"},  d_if.first_err_got, m_fg);
        check({tag, ".fexp"},  d_if.first_err_exp, m_fe);
    endtask

    // One clock of the default instance: drive, clock, update model, check.
    task automatic def_cycle(input string tag, input logic en, input logic pa,
                             input logic ld, input logic [7:0] ldv,
                             input logic cv, input logic [7:0] cd, input logic clr);
        logic mis;
        d_if.enable = en; d_if.pause = pa; d_if.load = ld; d_if.ldata = ldv;
        d_if.check_valid = cv; d_if.check_data = cd; d_if.clear_err = clr;
        @(posedge clk);
        mis = en && cv && (cd != m_data);
        if (clr) begin
            m_cnt = 0; m_sticky = 1'b0; m_fg = 8'h00; m_fe = 8'h00;
        end
        if (mis) begin
            if (!m_sticky) begin
                m_fg = cd; m_fe = m_data;
            end
            m_sticky = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        m_err = mis;
        if (!en)            m_data = 8'h20;
        else if (ld)        m_data = (ldv == 8'h00) ? 8'h20 : ldv;
        else if (!pa)       m_data = mulx(m_data);
        #1;
        check_def(tag);
        $display("cycle %s: data=0x%02h err=%0b cnt=%0d", tag, d_if.data, d_if.err, d_if.err_count);
    endtask

    task automatic idle_if(output logic en, output logic pa, output logic ld,
                           output logic [7:0] ldv, output logic cv,
                           output logic [7:0] cd, output logic clr);
        en = 1'b0; pa = 1'b0; ld = 1'b0; ldv = 8'h00; cv = 1'b0; cd = 8'h00; clr = 1'b0;
    endtask

    logic [7:0] tbl  [0:7];
    logic [7:0] tbl2 [0:3];
    logic [7:0] c_exp;
    int         c_want;

    initial begin
        tbl[0] = 8'h20; tbl[1] = 8'h40; tbl[2] = 8'h80; tbl[3] = 8'h1D;
        tbl[4] = 8'h3A; tbl[5] = 8'h74; tbl[6] = 8'hE8; tbl[7] = 8'hCD;
        tbl2[0] = 8'h20; tbl2[1] = 8'h80; tbl2[2] = 8'h3A; tbl2[3] = 8'hE8;
        idle_if(d_if.enable, d_if.pause, d_if.load, d_if.ldata, d_if.check_valid, d_if.check_data, d_if.clear_err);
        idle_if(s2_if.enable, s2_if.pause, s2_if.load, s2_if.ldata, s2_if.check_valid, s2_if.check_data, s2_if.clear_err);
        idle_if(c2_if.enable, c2_if.pause, c2_if.load, c2_if.ldata, c2_if.check_valid, c2_if.check_data, c2_if.clear_err);

        // Reset values
        #23;
        check_def("reset");
        check("reset.s2data", s2_if.data, 8'h20);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Free-running sequence, default and STEPS=2
        s2_if.enable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            def_cycle("seq", 1, 0, 0, 8'h00, 0, 8'h00, 0);
            check($sformatf("seq_tbl%0d", i), d_if.data, tbl[i]);
            if (i <= 3) check($sformatf("s2_tbl%0d", i), s2_if.data, tbl2[i]);
            if (i == 3) s2_if.enable = 1'b0;
        end
        for (int i = 8; i <= 255; i++) def_cycle("period", 1, 0, 0, 8'h00, 0, 8'h00, 0);
        check("period255", d_if.data, 8'h20);

        // Load, zero-load, pause, disable
        def_cycle("load5a", 1, 0, 1, 8'h5A, 0, 8'h00, 0);
        check("load5a_d", d_if.data, 8'h5A);
        def_cycle("load00", 1, 0, 1, 8'h00, 0, 8'h00, 0);
        check("load00_d", d_if.data, 8'h20);
        def_cycle("adv", 1, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            def_cycle("pause", 1, 1, 0, 8'h00, 0, 8'h00, 0);
            check("pause_d", d_if.data, 8'h40);
        end
        def_cycle("disable", 0, 0, 0, 8'h00, 0, 8'h00, 0);
        check("disable_d", d_if.data, 8'h20);

        // Checker: matching stream, then first and second mismatch
        for (int i = 0; i < 100; i++) def_cycle("match", 1, 0, 0, 8'h00, 1, m_data, 0);
        check("match_cnt", d_if.err_count, 16'd0);
        def_cycle("restart", 0, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) def_cycle("pre", 1, 0, 0, 8'h00, 1, m_data, 0);
        def_cycle("mis1", 1, 0, 0, 8'h00, 1, 8'h00, 0);
        check("mis1_err", d_if.err, 1'b1);
        check("mis1_cnt", d_if.err_count, 16'd1);
        check("mis1_fg", d_if.first_err_got, 8'h00);
        check("mis1_fe", d_if.first_err_exp, 8'h1D);
        def_cycle("ok", 1, 0, 0, 8'h00, 1, m_data, 0);
        check("ok_err", d_if.err, 1'b0);
        def_cycle("mis2", 1, 0, 0, 8'h00, 1, m_data ^ 8'hFF, 0);
        check("mis2_cnt", d_if.err_count, 16'd2);
        check("mis2_fe", d_if.first_err_exp, 8'h1D);
        def_cycle("clear", 1, 0, 0, 8'h00, 0, 8'h00, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic en, pa, ld, cv, clr;
            logic [7:0] ldv, cd;
            en  = ($urandom % 8) != 0;
            pa  = ($urandom % 4) == 0;
            ld  = ($urandom % 10) == 0;
            ldv = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
            cv  = ($urandom % 2) == 1;
            cd  = (($urandom % 4) == 0) ? 8'($urandom) : m_data;
            clr = ($urandom % 25) == 0;
            def_cycle("rand", en, pa, ld, ldv, cv, cd, clr);
        end

        // CNT_W=2 saturation and clear-with-mismatch
        c_exp = 8'h20;
        c2_if.enable = 1'b1;
        c2_if.check_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c2_if.check_data = ~c_exp;
            def_cycle("c2tick", 0, 0, 0, 8'h00, 0, 8'h00, 0);
            c_exp = mulx(c_exp);
            c_want = (i + 1 > 3) ? 3 : i + 1;
            check($sformatf("c2_sat%0d", i), c2_if.err_count, c_want);
        end
        c2_if.check_data = ~c_exp;
        c2_if.clear_err = 1'b1;
        def_cycle("c2tick", 0, 0, 0, 8'h00, 0, 8'h00, 0);
        check("c2_clr_cnt", c2_if.err_count, 2'd1);
        check("c2_clr_stky", c2_if.err_sticky, 1'b1);
        check("c2_clr_fe", c2_if.first_err_exp, mulx(mulx(mulx(mulx(mulx(8'h20))))));
        c2_if.clear_err = 1'b0;
        c2_if.check_valid = 1'b0;
        c2_if.enable = 1'b0;

        // Asynchronous reset between clock edges
        for (int i = 0; i < 5; i++) def_cycle("prearst", 1, 0, 0, 8'h00, 1, m_data ^ 8'h01, 0);
        #2;
        reset_n = 1'b0;
        #1;
        m_data = 8'h20; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0; m_fg = 8'h00; m_fe = 8'h00;
        check_def("arst");
        @(negedge clk);
        reset_n = 1'b1;
        def_cycle("postarst", 1, 0, 0, 8'h00, 0, 8'h00, 0);
        check("postarst_d", d_if.data, 8'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr3_top_ex_lfsr_chk.md
# ddr3_top_ex_lfsr_chk

Parametrised Galois LFSR pattern generator with a built-in pattern checker for the DDR3 example traffic driver. One instance produces write data, with WIDTH, polynomial, seed and steps-per-clock set by parameters. A second instance with the same parameters regenerates the expected sequence and checks read-back data against it, keeping error count and first-failure capture. This replaces fixed-width 8-bit generators in the driver datapath.

## Interface
- WIDTH, 8: LFSR and data width; legal range 3..64.
- POLY, 8'h1D: feedback mask, WIDTH bits; bit i set ⇒ MSB XORed into bit i. Bit 0 must be 1. Default corresponds to x^8+x^4+x^3+x^2+1.
- SEED, 32: reset/restart value, truncated to WIDTH bits; must be nonzero.
- STEPS, 1: LFSR iterations applied per advance; legal range 1..WIDTH.
- CNT_W, 16: width of the error counter.
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  0 ⇒ synchronous restart to SEED; checker idle.
- pause  in  1  1 ⇒ hold LFSR state.
- load  in  1  1 ⇒ load ldata (priority over advance).
- ldata  in  WIDTH  load value.
- data  out  WIDTH  current LFSR state (registered).
- check_valid  in  1  compare check_data against data this cycle.
- check_data  in  WIDTH  read-back word to check.
- clear_err  in  1  synchronous clear of checker status.
- err  out  1  registered one-cycle pulse on mismatch.
- err_sticky  out  1  set on any mismatch since reset/clear.
- err_count  out  CNT_W  mismatch count, saturating at 2^CNT_W-1.
- first_err_got  out  WIDTH  check_data of first mismatch since reset/clear.
- first_err_exp  out  WIDTH  expected data of first mismatch since reset/clear.

## Operation
- Single iteration f(s): next[0]=s[W-1]; next[i]=s[i-1]^(POLY[i]&s[W-1]) for i=1..W-1. An advance applies f STEPS times combinationally, i.e. the STEPS-fold composition of f within one cycle.
- State update priority per clock: !enable ⇒ SEED; else load ⇒ ldata, or SEED if ldata==0 (no lock-up); else !pause ⇒ f^STEPS(data); else hold.
- Checker is active only when enable=1 and check_valid=1. It compares check_data with the data value present in that same cycle, before the update. Advance is independent of check_valid; the driver ties pause to the read-valid inversion.
- On mismatch:
  - err=1 next cycle.
  - err_sticky set.
  - err_count incremented, saturating at 2^CNT_W-1.
  - first_err_got/exp captured only if err_sticky was 0.
- clear_err: err_sticky=0, err_count=0, first_err_* = 0.
- clear_err and a mismatch in the same cycle: the clear applies first, then the mismatch is recorded. Result is err_count=1, sticky=1, and first_err_* captured from this mismatch.
- enable=0 does not clear checker status; only clear_err or reset clears it.

## Timing
- Reset values: data=SEED[WIDTH-1:0], err=0, err_sticky=0, err_count=0, first_err_got=0, first_err_exp=0.
- data updates one clock after the controlling inputs; load and advance latency is 1 cycle.
- err, err_count, err_sticky and first_err_* update one clock after the check_valid cycle.
- Back-to-back check_valid every cycle is supported; err may stay high on consecutive cycles.
- Reset asserted mid-sequence: all outputs return to reset values immediately, independent of clk.
- Default configuration (POLY 8'h1D) has maximal period 255.

## Test plan
- Defaults, reset release, enable=1, pause=0 → data: 0x20, 0x40, 0x80, 0x1D, 0x3A, 0x74, 0xE8, 0xCD. After 255 advances data returns to 0x20.
- STEPS=2, otherwise defaults, enable=1 → data: 0x20, 0x80, 0x3A, 0xE8.
- load=1 with ldata=0x5A → data=0x5A next cycle. Then load=1 with ldata=0x00 → data=0x20. pause=1 for 3 cycles → data holds. enable=0 → data=0x20.
- Checker fed the matching sequence for 100 cycles → err never set, err_count=0. Then 0x00 is fed when 0x1D is expected → err pulses once, err_count=1, first_err_got=0x00, first_err_exp=0x1D. A later mismatch leaves first_err_* unchanged and makes err_count=2.
- CNT_W=2, 5 consecutive mismatches → err_count saturates at 3. clear_err is asserted together with a mismatch → err_count=1, err_sticky=1.
- reset_n pulsed low mid-sequence, asynchronously to clk → data=0x20 and all checker outputs 0 before the next clk edge.
